spi_controller: RTL
===================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning: SCLK half-period in clk cycles, legal values 2..255.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  transaction request; sampled only in IDLE.
REQ-005 rw  input  1  frame bit 15: 1 = write, 0 = read.
REQ-006 addr  input  7  register address; frame bits 14:8.
REQ-007 wdata  input  8  write data; frame bits 7:0.
REQ-008 cipo  input  1  serial data from the peripheral.
REQ-009 sclk  output  1  SPI clock, mode 0 (idles low).
REQ-010 copi  output  1  serial data to the peripheral, MSB first.
REQ-011 ncs  output  1  chip select, active-low.
REQ-012 busy  output  1  high from the cycle after start is accepted until return to IDLE.
REQ-013 done  output  1  single-cycle pulse at transaction end.
REQ-014 rdata  output  8  last 8 bits sampled from cipo; valid from the done pulse onward.

Function
REQ-015 States SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD and GAP.
REQ-016 IDLE with start=1 at cycle T0 SHALL latch {rw,addr,wdata} into a 16-bit shift register and enter SETUP at T0+1; start in any other state SHALL be ignored.
REQ-017 SETUP: ncs=0, sclk=0, copi=frame[15]; the state SHALL last CLK_DIV cycles, then go to SHIFT_HI.
REQ-018 SHIFT_HI: sclk=1 for CLK_DIV cycles; cipo SHALL be sampled into the receive register on the clk edge where sclk goes 0->1.
REQ-019 SHIFT_LO: sclk=0 for CLK_DIV cycles; copi SHALL change to the next bit on the same cycle sclk falls; copi SHALL never change while sclk=1.
REQ-020 Exactly 16 SHIFT_HI phases SHALL occur; after the 16th, go to HOLD (sclk=0, ncs=0) for CLK_DIV cycles.
REQ-021 ncs low duration SHALL be exactly 33*CLK_DIV cycles.
REQ-022 Leaving HOLD: ncs=1, done=1 for one cycle, and rdata SHALL load the bits sampled on rising edges 9..16, first-sampled bit as MSB.
REQ-023 GAP: ncs=1, busy=1 for CLK_DIV cycles, then IDLE; start held high SHALL launch the next frame on the first IDLE cycle.
REQ-024 In IDLE: ncs=1, sclk=0, copi=0, busy=0.
REQ-025 A write frame SHALL still sample cipo; rdata SHALL update on every done.
REQ-026 The bit counter SHALL be 5 bits and saturate at 16; the divider counter SHALL be 8 bits and reload at CLK_DIV-1.

Reset
REQ-027 rst_n=0 SHALL immediately force ncs=1, sclk=0, copi=0, busy=0, done=0, rdata=0x00 and state IDLE, including mid-frame; no done SHALL be produced for an aborted frame.
REQ-028 After rst_n deassertion, the first start SHALL be accepted no earlier than the first rising clk edge on which rst_n is high.

Structure
REQ-029 Package spi_ctrl_pkg SHALL hold the state enum plus FRAME_W=16, ADDR_W=7 and DATA_W=8.
REQ-030 Sub-module spi_sclk_gen SHALL hold the CLK_DIV divider and emit one-cycle rise/fall strobes; the FSM and shift registers stay in spi_controller.

Verification
REQ-031 CLK_DIV=4, write addr 0x01 data 0xA5 -> copi sampled at sclk rises reads 0x81A5; 16 rising edges; ncs low 132 cycles; done=1 for exactly 1 cycle.
REQ-032 Read addr 0x04 with the bench driving cipo 0x3C on bits 7..0 (changing on sclk falls) -> rdata=0x3C at done.
REQ-033 start pulsed again during SHIFT_HI -> ignored; exactly 16 sclk rises and one done.
REQ-034 start held high for two frames -> ncs high for exactly CLK_DIV+1 cycles between frames; second frame bit-exact.
REQ-035 rst_n pulsed low after the 7th sclk rise -> ncs=1 and sclk=0 within the reset cycle; no done; the next frame is correct.
REQ-036 CLK_DIV=2, write addr 0x00 data 0xFF -> frame 0x80FF; ncs low 66 cycles.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and frame geometry for the SPI register-access controller.
package spi_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK phase timer: every controller state lasts CLK_DIV clk cycles; this
// block marks the last cycle of each phase and turns it into rise/fall strobes
// when the controller says the next phase changes the SCLK level.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic arm_rise,
  input  logic arm_fall,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  // Down-counter held at the reload value while idle so the first phase is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= RELOAD;
    end else if (!enable || div_cnt == 8'd0) begin
      div_cnt <= RELOAD;
    end else begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

  assign tick = enable && (div_cnt == 8'd0);
  assign rise = tick && arm_rise;
  assign fall = tick && arm_fall;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master issuing one 16-bit {rw, addr, wdata} frame per request
// and returning the last 8 bits clocked in from the peripheral.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       cipo,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  import spi_ctrl_pkg::*;

  state_t              state;
  state_t              next_state;
  logic [FRAME_W-1:0]  tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic [4:0]          bit_cnt;
  logic                tick;
  logic                rise;
  logic                fall;
  logic                accept;
  logic                arm_rise;
  logic                arm_fall;

  assign accept   = (state == IDLE) && start;
  assign arm_rise = (state == SETUP) || (state == SHIFT_LO);
  assign arm_fall = (state == SHIFT_HI);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state != IDLE),
    .arm_rise (arm_rise),
    .arm_fall (arm_fall),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall)
  );

  // State register; reset drops any frame in flight straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Phase sequencing and pin decode; after the 16th high phase skip the low phase and go to HOLD.
  always_comb begin
    next_state = state;
    sclk       = 1'b0;
    copi       = 1'b0;
    ncs        = 1'b1;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = SETUP;
      end
      SETUP: begin
        ncs  = 1'b0;
        copi = tx_sr[FRAME_W-1];
        if (tick) next_state = SHIFT_HI;
      end
      SHIFT_HI: begin
        ncs  = 1'b0;
        sclk = 1'b1;
        copi = tx_sr[FRAME_W-1];
        if (tick) next_state = (bit_cnt == 5'(FRAME_W)) ? HOLD : SHIFT_LO;
      end
      SHIFT_LO: begin
        ncs  = 1'b0;
        copi = tx_sr[FRAME_W-1];
        if (tick) next_state = SHIFT_HI;
      end
      HOLD: begin
        ncs  = 1'b0;
        copi = tx_sr[FRAME_W-1];
        if (tick) next_state = GAP;
      end
      GAP: begin
        if (tick) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift registers, rising-edge bit count, and the end-of-frame done/rdata update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= 5'd0;
      rdata   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_sr   <= {rw, addr, wdata};
        bit_cnt <= 5'd0;
      end
      if (rise) begin
        rx_sr <= {rx_sr[DATA_W-2:0], cipo};
        if (bit_cnt != 5'(FRAME_W)) bit_cnt <= bit_cnt + 5'd1;
      end
      if (fall) begin
        tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      end
      if ((state == HOLD) && tick) begin
        done  <= 1'b1;
        rdata <= rx_sr;
      end
    end
  end

endmodule
